// File: rtl/char_ram_writer_pkg.sv
// Shared constants, states and helpers for the character RAM writer.
// Imported by the top FSM and the cursor sub-module.
package char_ram_writer_pkg;

    localparam int COLS_DEF = 64;
    localparam int ROWS_DEF = 16;

    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_PR_LO = 8'h20;
    localparam logic [7:0] CH_PR_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        FULL_CLR,
        LINE_CLR
    } state_e;

    typedef enum logic [2:0] {
        CUR_NOP,
        CUR_ADV,
        CUR_NL,
        CUR_CR,
        CUR_HOME,
        CUR_BS
    } cur_op_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PR_LO) && (c <= CH_PR_HI);
    endfunction

endpackage

// File: rtl/char_ram_writer_cursor.sv
// Cursor column/row registers with advance, newline, CR, home and backspace.
// Rows wrap from ROWS-1 back to 0; eol_o flags the last column.
module char_cursor
    import char_ram_writer_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cur_op_e    op_i,
    output logic [5:0] col_o,
    output logic [3:0] row_o,
    output logic       eol_o
);

    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

    logic [5:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic [3:0] row_inc;

    assign row_inc = (row_q == ROW_MAX) ? 4'd0 : row_q + 4'd1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        unique case (op_i)
            CUR_ADV: begin
                if (col_q == COL_MAX) begin
                    col_d = 6'd0;
                    row_d = row_inc;
                end else begin
                    col_d = col_q + 6'd1;
                end
            end
            CUR_NL: begin
                col_d = 6'd0;
                row_d = row_inc;
            end
            CUR_CR: col_d = 6'd0;
            CUR_HOME: begin
                col_d = 6'd0;
                row_d = 4'd0;
            end
            CUR_BS: begin
                if (col_q != 6'd0) col_d = col_q - 6'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= 6'd0;
            row_q <= 4'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;
    assign eol_o = (col_q == COL_MAX);

endmodule

// File: rtl/char_ram_writer.sv
// Byte-stream to character RAM writer: cursor, control codes and
// line/screen blanking fills, with all RAM port outputs registered.
module char_ram_writer
    import char_ram_writer_pkg::*;
#(
    parameter int         COLS   = COLS_DEF,
    parameter int         ROWS   = ROWS_DEF,
    parameter int         ADDR_W = 14,
    parameter logic [7:0] BLANK  = CH_BLANK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    input  logic              clear,
    output logic              busy,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dia,
    output logic [5:0]        cur_col,
    output logic [3:0]        cur_row
);

    localparam int DEPTH = COLS * ROWS;
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [7:0]        dia_q, dia_d;
    cur_op_e           op;
    logic              eol;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] r,
                                                  input int c);
        return ADDR_W'(int'(r) * COLS + c);
    endfunction

    char_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk   (clk),
        .rst_n (rst_n),
        .op_i  (op),
        .col_o (cur_col),
        .row_o (cur_row),
        .eol_o (eol)
    );

    assign in_ready = (state_q == IDLE) && !clear;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dia_d   = dia_q;
        op      = CUR_NOP;
        // A clear outranks everything, including a byte offered this cycle
        if (clear) begin
            state_d = FULL_CLR;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        unique case (1'b1)
                            is_printable(in_char): begin
                                wea_d   = 1'b1;
                                addra_d = addr_of(cur_row, int'(cur_col));
                                dia_d   = in_char;
                                op      = CUR_ADV;
                                if (eol) begin
                                    state_d = LINE_CLR;
                                    cnt_d   = '0;
                                end
                            end
                            in_char == CH_LF: begin
                                op      = CUR_NL;
                                state_d = LINE_CLR;
                                cnt_d   = '0;
                            end
                            in_char == CH_CR: op = CUR_CR;
                            in_char == CH_BS: begin
                                if (cur_col != 6'd0) begin
                                    wea_d   = 1'b1;
                                    addra_d = addr_of(cur_row,
                                                      int'(cur_col - 6'd1));
                                    dia_d   = BLANK;
                                    op      = CUR_BS;
                                end
                            end
                            in_char == CH_FF: begin
                                state_d = FULL_CLR;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                LINE_CLR: begin
                    wea_d   = 1'b1;
                    addra_d = addr_of(cur_row, int'(cnt_q));
                    dia_d   = BLANK;
                    if (cnt_q == LINE_LAST) state_d = IDLE;
                    else cnt_d = cnt_q + 1'b1;
                end
                FULL_CLR: begin
                    wea_d   = 1'b1;
                    addra_d = ADDR_W'(cnt_q);
                    dia_d   = BLANK;
                    if (cnt_q == FULL_LAST) begin
                        state_d = IDLE;
                        op      = CUR_HOME;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dia_q   <= BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dia_q   <= dia_d;
        end
    end

    assign wea   = wea_q;
    assign addra = addra_q;
    assign dia   = dia_q;

endmodule

// File: tb/tb_char_ram_writer.sv
// Randomised bench for char_ram_writer against a queue-based screen model.
// Directed scenarios pin the model with literal expectations.
module tb_char_ram_writer;
    import char_ram_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        clear = 1'b0;
    logic        in_ready, busy, wea;
    logic [13:0] addra;
    logic [7:0]  dia;
    logic [5:0]  cur_col;
    logic [3:0]  cur_row;

    int checks = 0;
    int errors = 0;

    // Model: pending blank writes are a queue of addresses
    int m_col, m_row, m_addr, m_dia;
    bit m_wea, home_pend;
    int q[$];

    always #5 clk = ~clk;

    char_ram_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .clear    (clear),
        .busy     (busy),
        .wea      (wea),
        .addra    (addra),
        .dia      (dia),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic next_row();
        m_col = 0;
        m_row = (m_row + 1) % 16;
        for (int c = 0; c < 64; c++) q.push_back(m_row * 64 + c);
    endtask

    task automatic full_clear();
        q.delete();
        for (int a = 0; a < 1024; a++) q.push_back(a);
        home_pend = 1;
    endtask

    task automatic apply_byte(input int c);
        if (c >= 32 && c <= 126) begin
            m_wea = 1; m_addr = m_row * 64 + m_col; m_dia = c;
            m_col++;
            if (m_col == 64) next_row();
        end else if (c == 10) begin
            next_row();
        end else if (c == 13) begin
            m_col = 0;
        end else if (c == 8) begin
            if (m_col > 0) begin
                m_col--;
                m_wea = 1; m_addr = m_row * 64 + m_col; m_dia = 32;
            end
        end else if (c == 12) begin
            full_clear();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_col = 0; m_row = 0; m_wea = 0;
                m_addr = 0; m_dia = 32; home_pend = 0;
                q.delete();
            end else begin
                m_wea = 0;
                if (clear) begin
                    full_clear();
                end else if (q.size() != 0) begin
                    m_wea = 1; m_addr = q.pop_front(); m_dia = 32;
                    if (q.size() == 0 && home_pend) begin
                        m_col = 0; m_row = 0; home_pend = 0;
                    end
                end else if (in_valid) begin
                    apply_byte(int'(in_char));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", in_ready, (q.size() == 0) && !clear);
                chk("busy", busy, q.size() != 0);
                chk("wea", wea, m_wea);
                if (m_wea) begin
                    chk("addra", addra, m_addr);
                    chk("dia", dia, m_dia);
                end
                chk("cur_col", cur_col, m_col);
                chk("cur_row", cur_row, m_row);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 0; clear = 0; rst_n = 0;
        #2 rst_n = 1;
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        in_valid = 1; in_char = c;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL send_timeout: got busy expected ready");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n, w;
        logic [7:0] c;
        #12;
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dia", dia, 8'h20);
        chk("rst_busy", busy, 0);
        chk("rst_col", cur_col, 0);
        chk("rst_row", cur_row, 0);
        @(posedge clk); #1 rst_n = 1;

        send(8'h41);
        chk("ab_a_wea", wea, 1); chk("ab_a_addr", addra, 0);
        chk("ab_a_dia", dia, 8'h41);
        send(8'h42);
        chk("ab_b_addr", addra, 1); chk("ab_b_dia", dia, 8'h42);
        chk("ab_col", cur_col, 2); chk("ab_row", cur_row, 0);

        do_reset();
        for (int i = 0; i < 64; i++) send(8'h30 + 8'(i % 10));
        chk("wrap_last_addr", addra, 63);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin n++; @(negedge clk); end
        chk("wrap_busy_cycles", n, 64);
        chk("wrap_col", cur_col, 0); chk("wrap_row", cur_row, 1);
        chk("wrap_ready", in_ready, 1);

        do_reset();
        for (int i = 0; i < 15; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h61);
        wait_idle();
        chk("lf_pre_row", cur_row, 15); chk("lf_pre_col", cur_col, 10);
        send(8'h0A);
        chk("lf_nowrite", wea, 0);
        chk("lf_busy", busy, 1);
        wait_idle();
        chk("lf_col", cur_col, 0); chk("lf_row", cur_row, 0);

        do_reset();
        for (int i = 0; i < 3; i++) send(8'h0A);
        send(8'h08);
        chk("bs0_nowrite", wea, 0);
        chk("bs0_col", cur_col, 0); chk("bs0_row", cur_row, 3);
        for (int i = 0; i < 5; i++) send(8'h62);
        send(8'h08);
        chk("bs_wea", wea, 1); chk("bs_addr", addra, 196);
        chk("bs_dia", dia, 8'h20);
        chk("bs_col", cur_col, 4); chk("bs_row", cur_row, 3);

        wait_idle();
        clear = 1; in_valid = 1; in_char = 8'h41;
        @(negedge clk);
        chk("clr_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 0; in_valid = 0;
        w = 0;
        for (int i = 0; i < 1030; i++) begin
            @(negedge clk);
            if (wea) w++;
        end
        chk("clr_writes", w, 1024);
        chk("clr_col", cur_col, 0); chk("clr_row", cur_row, 0);

        send(8'h55); send(8'h0D); send(8'h56);
        clear = 1;
        @(posedge clk); #1 clear = 0;
        n = 0;
        @(negedge clk);
        while (!(wea && addra == 14'd500) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("mid_reach500", n < 2000, 1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_wea", wea, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_col", cur_col, 0); chk("mid_rst_row", cur_row, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        send(8'h5A);
        chk("z_addr", addra, 0); chk("z_dia", dia, 8'h5A);

        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 700) c = 8'($urandom_range(32, 126));
            else if (r < 760) c = 8'h0A;
            else if (r < 830) c = 8'h0D;
            else if (r < 930) c = 8'h08;
            else if (r < 933) c = 8'h0C;
            else c = 8'($urandom_range(0, 255));
            in_char = c;
            in_valid = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 799) == 0);
            @(posedge clk); #1;
        end
        in_valid = 0; clear = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/char_ram_writer.md
Name: char_ram_writer

Overview:
Write-side producer for the dual-port character RAM that backs the text display. Accepts a byte stream of ASCII characters over a valid/ready handshake and keeps a cursor. Drives the RAM write port (one write per cycle) and handles control codes, line wrap, screen wrap and clearing. Sits between the Fibonacci digit formatter (upstream) and the character RAM port A (downstream).

Parameters:
COLS, 64, characters per row
ROWS, 16, rows per screen; COLS*ROWS must be <= 1024 (RAM depth)
ADDR_W, 14, RAM write-address width
BLANK, 8'h20, fill character (ASCII space)

Ports:
clk  in  1  single clock; also drives RAM port A
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_char holds a byte
in_char  in  8  ASCII byte
in_ready  out  1  byte accepted on cycles where in_valid && in_ready
clear  in  1  single-cycle request: blank whole screen, cursor home
busy  out  1  high while any fill sequence is running
wea  out  1  RAM write enable
addra  out  ADDR_W  RAM write address = row*COLS+col, zero-extended
dia  out  8  RAM write data
cur_col  out  6  current cursor column
cur_row  out  4  current cursor row

Behaviour:
- Reset (async, rst_n=0): state IDLE, cur_col=0, cur_row=0, wea=0, addra=0, dia=BLANK, busy=0. No clear runs on reset exit; the RAM powers up blank.
- States: IDLE, FULL_CLR, LINE_CLR. busy = (state != IDLE). in_ready = (state==IDLE) && !clear (combinational).
- All RAM outputs are registered. A byte accepted in cycle t produces wea=1 with its addra/dia in cycle t+1. wea is 0 in every cycle with no write.
- Printable 0x20..0x7E: write the byte at (cur_row,cur_col), then col+1.
  - If col was COLS-1: col=0, row=(row+1) mod ROWS, enter LINE_CLR for the new row.
- 0x0A (LF): col=0, row=(row+1) mod ROWS, enter LINE_CLR. No character is written.
- 0x0D (CR): col=0, no write.
- 0x08 (BS): if col>0, col-1 and write BLANK at the new position. At col 0: no-op.
- 0x0C (FF): same as the clear input.
- Any other byte: consumed, no write, cursor unchanged.
- LINE_CLR: COLS consecutive cycles write BLANK at row*COLS+0 .. row*COLS+COLS-1 ascending, starting in the cycle after entry. Then IDLE. Cursor stays at (row,0).
- FULL_CLR: COLS*ROWS consecutive cycles write BLANK at addresses 0 .. COLS*ROWS-1 ascending. Then cursor (0,0) and IDLE.
- clear in IDLE: takes priority over a simultaneous in_valid (byte not accepted) and enters FULL_CLR.
- clear during LINE_CLR: aborts it and starts FULL_CLR at address 0 on the next cycle.
- clear during FULL_CLR: restarts the fill from address 0.
- Back-to-back printable bytes sustain one write per cycle with in_ready held high. Only LINE_CLR and FULL_CLR stall the stream.
- Screen wrap: row ROWS-1 advances to row 0. There is no scroll; the row being entered is blanked by LINE_CLR.
- Address arithmetic is unsigned. The fill counter is ceil(log2(COLS*ROWS)) bits wide and its terminal count is COLS*ROWS-1.

Decomposition:
- Shared package: ASCII constants (BLANK, LF, CR, BS, FF, printable range bounds), the state enum, and the COLS/ROWS defaults.
- Sub-module char_cursor: col/row counters with advance, newline, home and backspace operations, and row wrap. Shared by the top FSM.
- The fill counter and address formation stay in the top module.

Test Plan:
- Reset, then send "AB" back-to-back -> wea=1 at addr 0 data 0x41, next cycle addr 1 data 0x42; cursor (0,2); in_ready never drops.
- 64 printable bytes from (0,0) -> last write at addr 63. Then busy=1 for exactly 64 cycles writing 0x20 at addr 64..127. Cursor (1,0) and in_ready=1 afterwards.
- Cursor at (15,10), send 0x0A -> no char write; LINE_CLR writes 0x20 at addr 0..63; cursor (0,0).
- Cursor (3,0), send 0x08 -> no write, cursor unchanged. Cursor (3,5), send 0x08 -> write 0x20 at addr 196, cursor (3,4).
- clear asserted in the same cycle as in_valid=1, in_char=0x41 -> byte not accepted. 1024 writes of 0x20 at addr 0..1023, busy=1 throughout, cursor (0,0).
- Assert rst_n=0 mid-FULL_CLR (at addr 500) -> wea=0 and busy=0 immediately, cursor (0,0). After release, 'Z' writes 0x5A at addr 0.
